// File: rtl/dpmem_be.sv
// Single-clock simple-dual-port RAM with per-lane write enables.
// Also has read-during-write mode select, optional output register and a post-reset clear.
module dpmem_be #(
    parameter int DW           = 16,
    parameter int LANE_W       = 4,
    parameter int AW           = 4,
    parameter int DEPTH        = 16,
    parameter int RDW_MODE     = 0,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   busy,
    input  logic                   re,
    input  logic [AW-1:0]          ra,
    output logic [DW-1:0]          rd,
    output logic                   rd_valid,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [DW/LANE_W-1:0]   wbe,
    input  logic [DW-1:0]          wd
);

    localparam int NL = DW / LANE_W;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            run;
    logic            wa_ok, ra_ok;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [NL-1:0]   wr_mask;
    logic [DW-1:0]   wr_data;

    logic [DW-1:0]   mem_q [DEPTH];

    logic            rd_fire;
    logic [DW-1:0]   rdata;
    logic [DW-1:0]   rd1_q, rd1_d;
    logic            v1_q, v1_d;

    assign run   = (state_q == RUN);
    assign busy  = ~run;
    assign wa_ok = ({1'b0, wa} < DEPTH_W);
    assign ra_ok = ({1'b0, ra} < DEPTH_W);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The clear sequencer borrows the write port while busy.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wa;
        wr_mask = wbe;
        wr_data = wd;
        if (!rst) begin
            if (!run) begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_mask = '1;
                wr_data = '0;
            end else if (we && wa_ok) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NL; i++) begin
                if (wr_mask[i]) begin
                    mem_q[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rd_fire = run & re;

    always_comb begin
        rdata = '0;
        if (ra_ok) begin
            rdata = mem_q[ra];
            // Same-address write bypass: enabled lanes see the incoming data.
            if ((RDW_MODE != 0) && we && (wa == ra)) begin
                for (int i = 0; i < NL; i++) begin
                    if (wbe[i]) begin
                        rdata[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    always_comb begin
        rd1_d = rd1_q;
        v1_d  = rd_fire;
        if (rd_fire) begin
            rd1_d = rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            rd1_q <= rd1_d;
            v1_q  <= v1_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DW-1:0] rd2_q, rd2_d;
        logic          v2_q, v2_d;

        always_comb begin
            rd2_d = v1_q ? rd1_q : rd2_q;
            v2_d  = v1_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd2_q <= '0;
                v2_q  <= 1'b0;
            end else begin
                rd2_q <= rd2_d;
                v2_q  <= v2_d;
            end
        end

        assign rd       = rd2_q;
        assign rd_valid = v2_q;
    end else begin : g_nreg
        assign rd       = rd1_q;
        assign rd_valid = v1_q;
    end

endmodule
